// File: rtl/ddr_rd_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_arb_pkg
// Description : Shared types and constants for the DDR read-port arbiter:
//               2-bit FSM state encodings, default parameter values and the
//               fixed burst-length width.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_rd_arb_pkg;

    localparam int C_LEN_W               = 8;
    localparam int C_DEF_ADDR_WIDTH      = 30;
    localparam int C_DEF_MEM_DATA_BITS   = 256;
    localparam int C_DEF_NUM_REQ         = 4;
    localparam int C_DEF_TIMEOUT_CYCLES  = 4096;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_rd_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Returns the first set request
//               at or after the pointer (wrapping), as one-hot plus index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // One bit wider than the pointer so ptr+offset cannot overflow before wrap.
    logic [PTR_W:0] w_cand;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = (PTR_W+1)'(ptr) + (PTR_W+1)'(off);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!any && req[w_cand[PTR_W-1:0]]) begin
                gnt[w_cand[PTR_W-1:0]] = 1'b1;
                idx                    = w_cand[PTR_W-1:0];
                any                    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_port_arbiter
// Description : Round-robin arbiter sharing one DDR read port among NUM_REQ
//               burst requesters. Grant and burst descriptor are latched for
//               the whole transaction; return data is broadcast, valid and
//               finish are routed to the grantee.
//               Optional macro DDR_RD_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_port_arbiter
    import ddr_rd_arb_pkg::*;
#(
    parameter real TCQ            = 0.1,
    parameter int  ADDR_WIDTH     = C_DEF_ADDR_WIDTH,
    parameter int  MEM_DATA_BITS  = C_DEF_MEM_DATA_BITS,
    parameter int  NUM_REQ        = C_DEF_NUM_REQ,
    parameter int  TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input  logic                          ddr_clk_i,
    input  logic                          ddr_rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*C_LEN_W-1:0]    req_len_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            req_data_valid_o,
    output logic [MEM_DATA_BITS-1:0]      req_data_o,
    output logic [NUM_REQ-1:0]            req_finish_o,
    output logic                          rd_ddr_req_o,
    output logic [C_LEN_W-1:0]            rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]         rd_ddr_addr_o,
    input  logic                          rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]      rd_ddr_data_i,
    input  logic                          rd_ddr_finish_i,
    output logic                          arb_busy_o,
    output logic                          timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [NUM_REQ-1:0]      r_grant;
    logic [PTR_W-1:0]        r_grant_idx;
    logic [PTR_W-1:0]        r_ptr;
    logic                    r_ddr_req;
    logic [C_LEN_W-1:0]      r_len;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [NUM_REQ-1:0]      w_pick_gnt;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_pick_any;
    logic                    w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Next-state decode; a timeout exits WAIT the same way a finish does.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_any) w_state_nxt = ARB_ISSUE;
            ARB_ISSUE: w_state_nxt = ARB_WAIT;
            ARB_WAIT:  if (rd_ddr_finish_i || w_timeout) w_state_nxt = ARB_DONE;
            ARB_DONE:  w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    // State, grant, descriptor latch, DDR request and priority pointer.
    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_ddr_req   <= 1'b0;
            r_len       <= '0;
            r_addr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_grant     <= w_pick_gnt;
                        r_grant_idx <= w_pick_idx;
                        r_len       <= req_len_i[w_pick_idx*C_LEN_W +: C_LEN_W];
                        r_addr      <= req_addr_i[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_ddr_req   <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    r_grant   <= '0;
                    r_ddr_req <= 1'b0;
                    r_ptr     <= (r_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : r_grant_idx + 1'b1;
                end
                default: begin
                    // Request drops at the first sign the DDR side has accepted it.
                    if (rd_ddr_data_valid_i || rd_ddr_finish_i || (w_state_nxt == ARB_DONE)) begin
                        r_ddr_req <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef DDR_RD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Watchdog counts WAIT cycles since entry or since the last data beat.
    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            r_wd_cnt <= '0;
        end else if ((r_state == ARB_ISSUE) || ((r_state == ARB_WAIT) && rd_ddr_data_valid_i)) begin
            r_wd_cnt <= '0;
        end else if ((r_state == ARB_WAIT) && !w_timeout) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ARB_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign grant_o          = r_grant;
    assign req_data_valid_o = {NUM_REQ{rd_ddr_data_valid_i}} & r_grant;
    assign req_data_o       = rd_ddr_data_i;
    assign req_finish_o     = {NUM_REQ{rd_ddr_finish_i || w_timeout}} & r_grant;
    assign rd_ddr_req_o     = r_ddr_req;
    assign rd_ddr_len_o     = r_len;
    assign rd_ddr_addr_o    = r_addr;
    assign arb_busy_o       = (r_state != ARB_IDLE);
    assign timeout_o        = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_rd_port_arbiter
// Description : Directed self-checking bench for ddr_rd_port_arbiter with a
//               scoreboard of expected routed beats and finish pulses.
//               Honours DDR_RD_ARB_TIMEOUT_EN for the watchdog scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 30;
    localparam int DW      = 256;

    logic                    ddr_clk_i = 1'b0;
    logic                    ddr_rst_n_i = 1'b0;
    logic [NUM_REQ-1:0]      req_i = '0;
    logic [NUM_REQ*8-1:0]    req_len_i = '0;
    logic [NUM_REQ*AW-1:0]   req_addr_i = '0;
    logic [NUM_REQ-1:0]      grant_o;
    logic [NUM_REQ-1:0]      req_data_valid_o;
    logic [DW-1:0]           req_data_o;
    logic [NUM_REQ-1:0]      req_finish_o;
    logic                    rd_ddr_req_o;
    logic [7:0]              rd_ddr_len_o;
    logic [AW-1:0]           rd_ddr_addr_o;
    logic                    rd_ddr_data_valid_i = 1'b0;
    logic [DW-1:0]           rd_ddr_data_i = '0;
    logic                    rd_ddr_finish_i = 1'b0;
    logic                    arb_busy_o;
    logic                    timeout_o;

    int total = 0;
    int bad   = 0;
    int n_timeouts = 0;

    int            exp_idx_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            exp_fin_q[$];
    int            m_g;
    logic [DW-1:0] m_d;

    ddr_rd_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .MEM_DATA_BITS  (DW),
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ddr_clk_i           (ddr_clk_i),
        .ddr_rst_n_i         (ddr_rst_n_i),
        .req_i               (req_i),
        .req_len_i           (req_len_i),
        .req_addr_i          (req_addr_i),
        .grant_o             (grant_o),
        .req_data_valid_o    (req_data_valid_o),
        .req_data_o          (req_data_o),
        .req_finish_o        (req_finish_o),
        .rd_ddr_req_o        (rd_ddr_req_o),
        .rd_ddr_len_o        (rd_ddr_len_o),
        .rd_ddr_addr_o       (rd_ddr_addr_o),
        .rd_ddr_data_valid_i (rd_ddr_data_valid_i),
        .rd_ddr_data_i       (rd_ddr_data_i),
        .rd_ddr_finish_i     (rd_ddr_finish_i),
        .arb_busy_o          (arb_busy_o),
        .timeout_o           (timeout_o)
    );

    always #5 ddr_clk_i = ~ddr_clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every routed beat / finish must match the head entry.
    always @(negedge ddr_clk_i) begin
        if (|req_data_valid_o) begin
            if (exp_idx_q.size() == 0) begin
                chk("unexpected_valid", req_data_valid_o, '0);
            end else begin
                m_g = exp_idx_q.pop_front();
                m_d = exp_data_q.pop_front();
                chk("valid_route", req_data_valid_o, DW'(1 << m_g));
                chk("beat_data", req_data_o, m_d);
            end
        end
        if (|req_finish_o) begin
            if (exp_fin_q.size() == 0) begin
                chk("unexpected_finish", req_finish_o, '0);
            end else begin
                m_g = exp_fin_q.pop_front();
                chk("finish_route", req_finish_o, DW'(1 << m_g));
            end
        end
        if (timeout_o) n_timeouts++;
    end

    task automatic set_field(input int k, input logic [7:0] len, input logic [AW-1:0] addr);
        req_len_i[8*k +: 8]   = len;
        req_addr_i[AW*k +: AW] = addr;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, grant_o, '0);
        chk({tag, "_ddr_req"}, rd_ddr_req_o, '0);
        chk({tag, "_len"}, rd_ddr_len_o, '0);
        chk({tag, "_addr"}, rd_ddr_addr_o, '0);
        chk({tag, "_busy"}, arb_busy_o, '0);
        chk({tag, "_timeout"}, timeout_o, '0);
        chk({tag, "_valid_out"}, req_data_valid_o, '0);
        chk({tag, "_finish_out"}, req_finish_o, '0);
    endtask

    // Count low samples of rd_ddr_req_o before it rises, bounded.
    task automatic wait_req(input string tag, output int lows);
        lows = 0;
        while (lows < 20) begin
            @(negedge ddr_clk_i);
            if (rd_ddr_req_o) break;
            lows++;
        end
        chk({tag, "_req_seen"}, rd_ddr_req_o, 1'b1);
    endtask

    task automatic check_grant(input string tag, input int g, input logic [7:0] len, input logic [AW-1:0] addr);
        chk({tag, "_grant"}, grant_o, DW'(1 << g));
        chk({tag, "_len"}, rd_ddr_len_o, len);
        chk({tag, "_addr"}, rd_ddr_addr_o, addr);
        chk({tag, "_busy"}, arb_busy_o, 1'b1);
    endtask

    // Drive nbeats data beats then a finish pulse, recording expectations.
    task automatic serve(input int g, input int nbeats, input bit drop);
        for (int b = 0; b < nbeats; b++) begin
            @(posedge ddr_clk_i); #1;
            rd_ddr_data_valid_i = 1'b1;
            rd_ddr_data_i = {8{$urandom}};
            exp_idx_q.push_back(g);
            exp_data_q.push_back(rd_ddr_data_i);
            if (drop && b == 0) begin
                req_i      = '0;
                req_len_i  = ~req_len_i;
                req_addr_i = ~req_addr_i;
            end
            if (b == 1) chk("ddr_req_cleared_on_valid", rd_ddr_req_o, 1'b0);
        end
        @(posedge ddr_clk_i); #1;
        rd_ddr_data_valid_i = 1'b0;
        rd_ddr_finish_i = 1'b1;
        exp_fin_q.push_back(g);
        @(posedge ddr_clk_i); #1;
        rd_ddr_finish_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge ddr_clk_i); #1;
        ddr_rst_n_i = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge ddr_clk_i);
        #1;
        ddr_rst_n_i = 1'b1;
    endtask

    initial begin
        int lows;
        int cyc;

        // Reset state
        #2;
        check_idle_outputs("por");
        repeat (2) @(posedge ddr_clk_i);
        #1;
        ddr_rst_n_i = 1'b1;

        // Single requester 1, len 128, request one cycle after req_i
        set_field(1, 8'd128, 30'h1000_0080);
        req_i = 4'b0010;
        wait_req("single", lows);
        chk("single_latency", lows, 1);
        check_grant("single", 1, 8'd128, 30'h1000_0080);
        req_i = '0;
        serve(1, 128, 1'b0);
        repeat (3) @(negedge ddr_clk_i);
        chk("single_back_idle", arb_busy_o, 1'b0);
        chk("single_grant_clear", grant_o, '0);

        // All four from reset: order 0..3, two-cycle gap; requester 0 uses len 0
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_field(k, 8'(k * 16), 30'h0200_0000 + AW'(k * 'h100));
        req_i = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_req("rr", lows);
            chk("rr_gap", lows, (k == 0) ? 1 : 2);
            check_grant("rr", k, 8'(k * 16), 30'h0200_0000 + AW'(k * 'h100));
            if (k == NUM_REQ - 1) req_i = '0;
            serve(k, 3, 1'b0);
        end

        // Requester 2 drops req_i and its fields on the first beat
        set_field(2, 8'd77, 30'h0ABC_DE00);
        set_field(0, 8'd1, 30'h0000_0100);
        set_field(3, 8'd3, 30'h0000_0300);
        @(posedge ddr_clk_i); #1;
        req_i = 4'b0100;
        wait_req("drop", lows);
        check_grant("drop", 2, 8'd77, 30'h0ABC_DE00);
        serve(2, 4, 1'b1);
        chk("drop_len_held", rd_ddr_len_o, 8'd77);
        chk("drop_addr_held", rd_ddr_addr_o, 30'h0ABC_DE00);
        // Pointer is now 3: with 0 and 3 requesting, 3 must win
        set_field(0, 8'd1, 30'h0000_0100);
        set_field(3, 8'd3, 30'h0000_0300);
        req_i = 4'b1001;
        wait_req("ptr3", lows);
        check_grant("ptr3", 3, 8'd3, 30'h0000_0300);
        req_i = '0;
        serve(3, 2, 1'b0);
        repeat (3) @(negedge ddr_clk_i);

        // Stray return traffic in IDLE is dropped
        @(posedge ddr_clk_i); #1;
        rd_ddr_finish_i = 1'b1;
        rd_ddr_data_valid_i = 1'b1;
        @(negedge ddr_clk_i);
        chk("stray_finish_out", req_finish_o, '0);
        chk("stray_valid_out", req_data_valid_o, '0);
        @(posedge ddr_clk_i); #1;
        rd_ddr_finish_i = 1'b0;
        rd_ddr_data_valid_i = 1'b0;
        @(negedge ddr_clk_i);
        chk("stray_busy", arb_busy_o, 1'b0);
        chk("stray_ddr_req", rd_ddr_req_o, 1'b0);

        // Reset during beat 40 of 128, then requester 3 from reset
        set_field(0, 8'd128, 30'h0300_0000);
        @(posedge ddr_clk_i); #1;
        req_i = 4'b0001;
        wait_req("rst_mid", lows);
        check_grant("rst_mid", 0, 8'd128, 30'h0300_0000);
        req_i = '0;
        for (int b = 0; b < 40; b++) begin
            @(posedge ddr_clk_i); #1;
            rd_ddr_data_valid_i = 1'b1;
            rd_ddr_data_i = {8{$urandom}};
            exp_idx_q.push_back(0);
            exp_data_q.push_back(rd_ddr_data_i);
        end
        @(posedge ddr_clk_i); #1;
        ddr_rst_n_i = 1'b0;
        rd_ddr_finish_i = 1'b1;
        #1;
        check_idle_outputs("rst_mid_async");
        repeat (2) @(posedge ddr_clk_i);
        #1;
        rd_ddr_data_valid_i = 1'b0;
        rd_ddr_finish_i = 1'b0;
        ddr_rst_n_i = 1'b1;
        set_field(3, 8'd9, 30'h0000_0900);
        req_i = 4'b1000;
        wait_req("after_rst", lows);
        chk("after_rst_latency", lows, 1);
        check_grant("after_rst", 3, 8'd9, 30'h0000_0900);
        req_i = '0;
        serve(3, 2, 1'b0);
        repeat (3) @(negedge ddr_clk_i);

`ifdef DDR_RD_ARB_TIMEOUT_EN
        // No return data: watchdog fires 16 cycles after entering WAIT
        set_field(1, 8'd4, 30'h0000_0444);
        @(posedge ddr_clk_i); #1;
        req_i = 4'b0010;
        wait_req("wd", lows);
        req_i = '0;
        exp_fin_q.push_back(1);
        @(posedge ddr_clk_i);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge ddr_clk_i);
            if (timeout_o) break;
            @(posedge ddr_clk_i);
            cyc++;
        end
        chk("wd_cycles", cyc, 16);
        chk("wd_finish", req_finish_o, 4'b0010);
        @(negedge ddr_clk_i);
        chk("wd_pulse_once", timeout_o, 1'b0);
        @(negedge ddr_clk_i);
        chk("wd_idle", arb_busy_o, 1'b0);
        chk("wd_timeout_count", n_timeouts, 1);
`else
        cyc = 0;
        chk("no_timeout", n_timeouts, 0);
`endif

        chk("sb_beats_drained", exp_idx_q.size(), 0);
        chk("sb_finish_drained", exp_fin_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
